// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: fetch FSM states, NOP encoding, default reset PC.
package rv32_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer with valid/ready on both sides and a synchronous flush.
module fetch_skid_buf #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_flush,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_valid && !r_valid) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_ready = !r_valid;
   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: single-outstanding imem requests, registered decode output with skid.
// Optional FETCH_MISALIGN_EN: misaligned redirect sets sticky fetch_fault and halts fetch.
module fetch_unit
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pcplus4,
   output logic        fetch_fault
);

   fetch_state_t r_state, w_state_nxt;
   logic [31:0]  r_pc, w_pc_nxt;
   logic [31:0]  r_req_pc, w_req_pc_nxt;
   logic         r_kill, w_kill_nxt;
   logic [31:0]  w_redir_pc;
   logic         w_take;

   logic         r_out_valid;
   logic [31:0]  r_out_instr, r_out_pc, r_out_pcplus4;
   logic         w_resp, w_out_load, w_skid_load, w_drain;
   logic         w_skid_valid, w_skid_ready;
   logic [63:0]  w_skid_data;

`ifdef FETCH_MISALIGN_EN
   logic r_fault;
   logic w_misalign;
   assign w_misalign  = (redirect_pc[1:0] != 2'b00);
   assign w_redir_pc  = redirect_pc;
   assign fetch_fault = r_fault;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_fault <= 1'b0;
      else        r_fault <= r_fault | (redirect && w_misalign);
   end
`else
   logic w_unused_lsb;
   assign w_unused_lsb = ^redirect_pc[1:0];
   assign w_redir_pc   = {redirect_pc[31:2], 2'b00};
   assign fetch_fault  = 1'b0;
`endif

   assign imem_req  = (r_state == REQ) && !w_skid_valid && rst_n;
   assign imem_addr = r_pc;
   assign w_take    = imem_req && imem_gnt;

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_req_pc_nxt = r_req_pc;
      w_kill_nxt   = r_kill;
      unique case (r_state)
         REQ: begin
            if (w_take) begin
               w_state_nxt  = WAIT;
               w_pc_nxt     = r_pc + 32'd4;
               w_req_pc_nxt = r_pc;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               w_state_nxt = REQ;
               w_kill_nxt  = 1'b0;
            end
         end
         default: ;
      endcase
      // A request still in flight after a redirect is tagged with kill so its data is dropped.
      if (redirect && (r_state != HALT)) begin
         w_pc_nxt = w_redir_pc;
         if (((r_state == WAIT) && !imem_rvalid) || ((r_state == REQ) && w_take)) begin
            w_state_nxt = WAIT;
            w_kill_nxt  = 1'b1;
         end else begin
            w_state_nxt = REQ;
            w_kill_nxt  = 1'b0;
         end
`ifdef FETCH_MISALIGN_EN
         if (w_misalign) begin
            w_state_nxt = HALT;
            w_kill_nxt  = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= REQ;
         r_pc     <= RESET_PC;
         r_req_pc <= '0;
         r_kill   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_req_pc <= w_req_pc_nxt;
         r_kill   <= w_kill_nxt;
      end
   end

   assign w_resp      = (r_state == WAIT) && imem_rvalid && !r_kill && !redirect;
   assign w_out_load  = w_resp && (!r_out_valid || id_ready);
   assign w_skid_load = w_resp && r_out_valid && !id_ready && w_skid_ready;
   assign w_drain     = r_out_valid && id_ready;

   fetch_skid_buf #(.W(64)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (redirect),
      .i_valid (w_skid_load),
      .o_ready (w_skid_ready),
      .i_data  ({imem_rdata, r_req_pc}),
      .o_valid (w_skid_valid),
      .i_ready (w_drain && !w_resp),
      .o_data  (w_skid_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid   <= 1'b0;
         r_out_instr   <= NOP_INSTR;
         r_out_pc      <= '0;
         r_out_pcplus4 <= 32'd4;
      end else if (redirect) begin
         r_out_valid <= 1'b0;
      end else if (w_out_load) begin
         r_out_valid   <= 1'b1;
         r_out_instr   <= imem_rdata;
         r_out_pc      <= r_req_pc;
         r_out_pcplus4 <= r_req_pc + 32'd4;
      end else if (w_drain) begin
         if (w_skid_valid) begin
            r_out_valid   <= 1'b1;
            r_out_instr   <= w_skid_data[63:32];
            r_out_pc      <= w_skid_data[31:0];
            r_out_pcplus4 <= w_skid_data[31:0] + 32'd4;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign id_valid   = r_out_valid;
   assign id_instr   = r_out_instr;
   assign id_pc      = r_out_pc;
   assign id_pcplus4 = r_out_pcplus4;

endmodule
